// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes device lines, latches them as pending, masks them and
// drives a fixed-priority irq/cause pair to the CPU. Software access is over a STB/ACK slave bus.
module int_ctrl #(
  parameter int unsigned NUM_SRC  = 6,
  parameter logic [31:0] RST_MASK = 32'h0,
  parameter logic [31:0] RST_EDGE = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               STB,
  input  logic               WE,
  input  logic [31:0]        ADDR,
  input  logic [31:0]        DAT_I,
  output logic [31:0]        DAT_O,
  output logic               ACK,
  output logic               irq,
  output logic [31:0]        cause
);

  typedef enum logic {StIdle, StDone} bus_state_e;

  bus_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] actv, rise, w1c;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               irq_q, irq_d;
  logic [4:0]         cause_q, cause_d;
  logic [1:0]         sel;
  logic               unused_bits;

  assign sel         = ADDR[3:2];
  assign actv        = pending_q & mask_q;
  assign rise        = s2_q & ~s3_q;
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  function automatic logic [31:0] zext(input logic [NUM_SRC-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_SRC-1:0] = v;
    return r;
  endfunction

  // Bus handshake: the access happens only on the IDLE->DONE transition, so a long STB
  // assertion executes a write or W1C exactly once.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    edge_d  = edge_q;
    w1c     = '0;
    unique case (state_q)
      StIdle: begin
        if (STB) begin
          state_d = StDone;
          ack_d   = 1'b1;
          if (WE) begin
            case (sel)
              2'd0:    w1c    = DAT_I[NUM_SRC-1:0];
              2'd1:    mask_d = DAT_I[NUM_SRC-1:0];
              2'd2:    edge_d = DAT_I[NUM_SRC-1:0];
              default: ;
            endcase
          end else begin
            case (sel)
              2'd0:    dat_d = zext(pending_q);
              2'd1:    dat_d = zext(mask_q);
              2'd2:    dat_d = zext(edge_q);
              default: dat_d = {irq_q, 26'b0, cause_q};
            endcase
          end
        end
      end
      StDone: begin
        if (!STB) begin
          state_d = StIdle;
          ack_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Edge-mode bits: clear first, then set, so a same-cycle rise wins over W1C.
  // Level-mode bits follow the synchronized line and ignore W1C.
  always_comb begin
    pending_d = (edge_q & ((pending_q & ~w1c) | rise)) | (~edge_q & s2_q);
  end

  // Lowest index has highest priority, so scan downward and let low bits overwrite.
  always_comb begin
    irq_d   = |actv;
    cause_d = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (actv[i]) cause_d = i[4:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      mask_q    <= RST_MASK[NUM_SRC-1:0];
      edge_q    <= RST_EDGE[NUM_SRC-1:0];
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= src;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
      cause_q   <= cause_d;
    end
  end

  assign DAT_O = dat_q;
  assign ACK   = ack_q;
  assign irq   = irq_q;
  assign cause = {27'b0, cause_q};

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: register access, priority, edge/level modes, single-shot writes
// under long strobes, masking and reset mid-transaction.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  src;
  logic        STB, WE;
  logic [31:0] ADDR, DAT_I, DAT_O, cause;
  logic        ACK, irq;

  int checks = 0;
  int errors = 0;

  int_ctrl #(.NUM_SRC(6), .RST_MASK(32'h0), .RST_EDGE(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .src(src), .STB(STB), .WE(WE), .ADDR(ADDR), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK(ACK), .irq(irq), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ACK) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ack"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    STB = 1'b1; WE = 1'b1; ADDR = addr; DAT_I = data;
    wait_ack("wr");
    STB = 1'b0; WE = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    STB = 1'b1; WE = 1'b0; ADDR = addr;
    wait_ack("rd");
    data = DAT_O;
    STB = 1'b0;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [31:0] rd;
  int          ack_rises;
  logic        ack_prev;

  initial begin
    rst = 1'b1; src = '0; STB = 1'b0; WE = 1'b0; ADDR = '0; DAT_I = '0;
    cycles(3);
    check("rst_ack", {31'b0, ACK}, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_cause", cause, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset register values
    bus_read(32'h0, rd); check("t1_pending", rd, 32'h0);
    bus_read(32'h4, rd); check("t1_mask", rd, 32'h0);
    bus_read(32'h8, rd); check("t1_edge", rd, 32'h3F);
    bus_read(32'hC, rd); check("t1_cause", rd, 32'h0);

    // 2: single pulse latency, W1C clears irq
    bus_write(32'h4, 32'h3F);
    bus_read(32'h4, rd); check("t2_mask", rd, 32'h3F);
    src[3] = 1'b1;
    @(negedge clk); src[3] = 1'b0;
    cycles(2);
    check("t2_irq_early", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("t2_irq", {31'b0, irq}, 32'd1);
    check("t2_cause", cause, 32'd3);
    bus_write(32'h0, 32'h08);
    check("t2_irq_clr", {31'b0, irq}, 32'd0);

    // 3: priority
    src = 6'h12;
    @(negedge clk); src = '0;
    cycles(3);
    check("t3_cause1", cause, 32'd1);
    bus_write(32'h0, 32'h02);
    check("t3_cause4", cause, 32'd4);
    check("t3_irq4", {31'b0, irq}, 32'd1);
    bus_write(32'h0, 32'h10);
    check("t3_irq0", {31'b0, irq}, 32'd0);
    check("t3_cause0", cause, 32'd0);

    // 4: level mode ignores W1C and tracks the line
    bus_write(32'h8, 32'h00);
    src[2] = 1'b1;
    cycles(4);
    bus_read(32'h0, rd); check("t4_level_set", rd, 32'h04);
    check("t4_cause", cause, 32'd2);
    bus_write(32'h0, 32'h04);
    bus_read(32'h0, rd); check("t4_w1c_noeff", rd, 32'h04);
    src[2] = 1'b0;
    cycles(3);
    check("t4_irq_still", {31'b0, irq}, 32'd1);
    @(negedge clk);
    check("t4_irq_drop", {31'b0, irq}, 32'd0);
    bus_read(32'h0, rd); check("t4_level_clr", rd, 32'h0);
    bus_write(32'h8, 32'h3F);

    // 5: long strobe executes the W1C once
    STB = 1'b1; WE = 1'b1; ADDR = 32'h0; DAT_I = 32'h01;
    ack_rises = 0; ack_prev = ACK;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) src[0] = 1'b1;
      if (i == 21) src[0] = 1'b0;
      @(negedge clk);
      if (ACK && !ack_prev) ack_rises++;
      ack_prev = ACK;
    end
    STB = 1'b0; WE = 1'b0;
    cycles(2);
    check("t5_ack_rises", ack_rises, 32'd1);
    bus_read(32'h0, rd); check("t5_pending", rd, 32'h01);
    bus_write(32'h0, 32'h01);
    bus_read(32'h0, rd); check("t5_cleared", rd, 32'h0);
    // rise reaches PENDING on the same edge as the W1C
    src[0] = 1'b1;
    @(negedge clk); src[0] = 1'b0;
    @(negedge clk);
    bus_write(32'h0, 32'h01);
    bus_read(32'h0, rd); check("t5_set_wins", rd, 32'h01);
    bus_write(32'h0, 32'h01);

    // 6: masking, unmask, reset mid-transaction
    bus_write(32'h4, 32'h00);
    src[5] = 1'b1;
    @(negedge clk); src[5] = 1'b0;
    cycles(4);
    check("t6_irq_masked", {31'b0, irq}, 32'd0);
    bus_read(32'h0, rd); check("t6_pending", rd, 32'h20);
    bus_write(32'h4, 32'h20);
    check("t6_irq", {31'b0, irq}, 32'd1);
    check("t6_cause", cause, 32'd5);
    bus_read(32'hC, rd); check("t6_cause_reg", rd, 32'h8000_0005);
    STB = 1'b1; WE = 1'b0; ADDR = 32'h4;
    @(negedge clk);
    check("t6_ack_pre", {31'b0, ACK}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ack_rst", {31'b0, ACK}, 32'd0);
    check("t6_irq_rst", {31'b0, irq}, 32'd0);
    check("t6_cause_rst", cause, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_reexec_ack", {31'b0, ACK}, 32'd1);
    check("t6_reexec_mask", DAT_O, 32'h0);
    STB = 1'b0;
    @(negedge clk);
    bus_read(32'h0, rd); check("t6_pending_rst", rd, 32'h0);
    bus_read(32'h8, rd); check("t6_edge_rst", rd, 32'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
